mmu_cell_simd: RTL and testbench

- Next-generation systolic MPU processing element.
- Each cycle it forwards LANES packed A/B operands to its east/south neighbours and accumulates their dot product into a local accumulator.
- The result register is double-buffered: a finished result drains down the c shift chain while the next tile is already accumulating.
- Adds signed/unsigned operand mode, a valid qualifier, optional saturation, and a per-result sticky overflow flag that travels with the result.

---
 rtl/mpu_pkg.sv | 36 +++
 rtl/mmu_simd_mac.sv | 76 +++++++
 rtl/mmu_cell_simd.sv | 94 +++++++++
 tb/tb_mmu_cell_simd.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// Shared helpers for the SIMD systolic MPU cell: width arithmetic and the
// edge-event bundle the cell hands to its accumulator.
package mpu_pkg;

   localparam int VAR_SIZE_DEF = 8;
   localparam int ACC_SIZE_DEF = 32;
   localparam int LANES_DEF    = 4;

   typedef struct packed {
      logic clr_rise;
      logic sh_rise;
   } edge_t;

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

   // One extra bit per operand for the signed/unsigned extension, plus
   // headroom for summing the lanes without loss.
   function automatic int dot_width(input int var_size, input int lanes);
      return 2 * var_size + 2 + clog2(lanes);
   endfunction

   function automatic int sum_width(input int acc_size, input int dw);
      return acc_size + dw + 1;
   endfunction

endpackage

// File: rtl/mmu_simd_mac.sv
// Dot-product accumulator: lane extension, exact adder tree, restart with bias,
// and saturate-or-wrap on overflow with a sticky flag.
module mmu_simd_mac
   import mpu_pkg::*;
#(
   parameter int VAR_SIZE = 8,
   parameter int ACC_SIZE = 32,
   parameter int LANES    = 4,
   parameter int SATURATE = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [LANES*VAR_SIZE-1:0] a,
   input  logic [LANES*VAR_SIZE-1:0] b,
   input  logic                      valid,
   input  logic                      signed_mode,
   input  logic                      restart,
   input  logic [ACC_SIZE-1:0]       bias,
   output logic [ACC_SIZE-1:0]       acc,
   output logic                      ovf
);

   localparam int PW = 2 * VAR_SIZE + 2;
   localparam int DW = dot_width(VAR_SIZE, LANES);
   localparam int SW = sum_width(ACC_SIZE, DW);

   localparam logic signed [SW-1:0] ACC_MAX = {{(SW-ACC_SIZE+1){1'b0}}, {(ACC_SIZE-1){1'b1}}};
   localparam logic signed [SW-1:0] ACC_MIN = {{(SW-ACC_SIZE+1){1'b1}}, {(ACC_SIZE-1){1'b0}}};

   logic signed [VAR_SIZE:0] ext_a [LANES];
   logic signed [VAR_SIZE:0] ext_b [LANES];
   logic signed [PW-1:0]     prod  [LANES];
   logic signed [DW-1:0]     dot;
   logic signed [SW-1:0]     base;
   logic signed [SW-1:0]     addend;
   logic signed [SW-1:0]     sum;
   logic                     ovf_now;
   logic [ACC_SIZE-1:0]      acc_next;

   always_comb begin
      dot = '0;
      for (int i = 0; i < LANES; i++) begin
         ext_a[i] = {signed_mode & a[i*VAR_SIZE+VAR_SIZE-1], a[i*VAR_SIZE +: VAR_SIZE]};
         ext_b[i] = {signed_mode & b[i*VAR_SIZE+VAR_SIZE-1], b[i*VAR_SIZE +: VAR_SIZE]};
         prod[i]  = PW'(ext_a[i]) * PW'(ext_b[i]);
         dot      = dot + DW'(prod[i]);
      end
   end

   // The sum is formed wide enough to be exact, so overflow is a plain range test.
   always_comb begin
      base    = restart ? SW'($signed(bias)) : SW'($signed(acc));
      addend  = valid ? SW'(dot) : '0;
      sum     = base + addend;
      ovf_now = (sum > ACC_MAX) || (sum < ACC_MIN);
      if (ovf_now && (SATURATE != 0)) begin
         acc_next = sum[SW-1] ? ACC_MIN[ACC_SIZE-1:0] : ACC_MAX[ACC_SIZE-1:0];
      end else begin
         acc_next = sum[ACC_SIZE-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (restart) begin
         acc <= acc_next;
         ovf <= ovf_now;
      end else if (valid) begin
         acc <= acc_next;
         ovf <= ovf | ovf_now;
      end
   end

endmodule

// File: rtl/mmu_cell_simd.sv
// Systolic SIMD processing element: forwards operands east/south, accumulates
// their dot product, and drains finished results down a double-buffered c chain.
module mmu_cell_simd
   import mpu_pkg::*;
#(
   parameter int VAR_SIZE = VAR_SIZE_DEF,
   parameter int ACC_SIZE = ACC_SIZE_DEF,
   parameter int LANES    = LANES_DEF,
   parameter int SATURATE = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [LANES*VAR_SIZE-1:0] a_in,
   input  logic [LANES*VAR_SIZE-1:0] b_in,
   input  logic                      valid_in,
   input  logic                      signed_mode,
   input  logic [ACC_SIZE-1:0]       bias,
   input  logic                      clear_in,
   input  logic                      shift_in,
   input  logic [ACC_SIZE-1:0]       c_in,
   input  logic                      ovf_in,
   output logic [LANES*VAR_SIZE-1:0] a_out,
   output logic [LANES*VAR_SIZE-1:0] b_out,
   output logic                      valid_out,
   output logic                      signed_out,
   output logic                      clear_out,
   output logic                      shift_out,
   output logic [ACC_SIZE-1:0]       c_out,
   output logic                      ovf_out
);

   edge_t               edges;
   logic                restart;
   logic [ACC_SIZE-1:0] acc;
   logic                ovf;

   // The forwarded copies double as the previous-cycle samples for edge detection.
   always_comb begin
      edges.clr_rise = clear_in & ~clear_out;
      edges.sh_rise  = shift_in & ~shift_out;
      restart        = edges.clr_rise | edges.sh_rise;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_out      <= '0;
         b_out      <= '0;
         valid_out  <= 1'b0;
         signed_out <= 1'b0;
         clear_out  <= 1'b0;
         shift_out  <= 1'b0;
      end else begin
         a_out      <= a_in;
         b_out      <= b_in;
         valid_out  <= valid_in;
         signed_out <= signed_mode;
         clear_out  <= clear_in;
         shift_out  <= shift_in;
      end
   end

   // A shift rise captures the finished tile while the accumulator restarts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_out   <= '0;
         ovf_out <= 1'b0;
      end else if (edges.sh_rise) begin
         c_out   <= acc;
         ovf_out <= ovf;
      end else if (shift_in) begin
         c_out   <= c_in;
         ovf_out <= ovf_in;
      end
   end

   mmu_simd_mac #(
      .VAR_SIZE (VAR_SIZE),
      .ACC_SIZE (ACC_SIZE),
      .LANES    (LANES),
      .SATURATE (SATURATE)
   ) u_mac (
      .clk         (clk),
      .rst_n       (rst_n),
      .a           (a_in),
      .b           (b_in),
      .valid       (valid_in),
      .signed_mode (signed_mode),
      .restart     (restart),
      .bias        (bias),
      .acc         (acc),
      .ovf         (ovf)
   );

endmodule

// File: tb/tb_mmu_cell_simd.sv
// Bench for mmu_cell_simd: three instances (32-bit saturating, 16-bit saturating,
// 16-bit wrapping) driven in lockstep and compared against an arithmetic model.
module tb_mmu_cell_simd;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] a_in = '0;
   logic [31:0] b_in = '0;
   logic        valid_in = 1'b0;
   logic        signed_mode = 1'b0;
   logic [31:0] bias = '0;
   logic        clear_in = 1'b0;
   logic        shift_in = 1'b0;
   logic [31:0] c_in = '0;
   logic        ovf_in = 1'b0;

   logic [31:0] a_out32, b_out32, c_out32;
   logic        valid_out32, signed_out32, clear_out32, shift_out32, ovf_out32;
   logic [31:0] a_out16s, b_out16s;
   logic [15:0] c_out16s;
   logic        valid_out16s, signed_out16s, clear_out16s, shift_out16s, ovf_out16s;
   logic [31:0] a_out16w, b_out16w;
   logic [15:0] c_out16w;
   logic        valid_out16w, signed_out16w, clear_out16w, shift_out16w, ovf_out16w;

   int checks = 0;
   int errors = 0;

   longint      m_acc  [3];
   longint      m_c    [3];
   bit          m_ovf  [3];
   bit          m_covf [3];
   logic [31:0] m_a, m_b;
   bit          m_valid, m_sgn, m_clear, m_shift;
   int          cfg_bits [3] = '{32, 16, 16};
   bit          cfg_sat  [3] = '{1'b1, 1'b1, 1'b0};

   longint tile_sum;
   longint next_tile;

   always #5 clk = ~clk;

   mmu_cell_simd #(.VAR_SIZE(8), .ACC_SIZE(32), .LANES(4), .SATURATE(1)) dut32 (
      .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .valid_in(valid_in),
      .signed_mode(signed_mode), .bias(bias), .clear_in(clear_in), .shift_in(shift_in),
      .c_in(c_in), .ovf_in(ovf_in), .a_out(a_out32), .b_out(b_out32),
      .valid_out(valid_out32), .signed_out(signed_out32), .clear_out(clear_out32),
      .shift_out(shift_out32), .c_out(c_out32), .ovf_out(ovf_out32));

   mmu_cell_simd #(.VAR_SIZE(8), .ACC_SIZE(16), .LANES(4), .SATURATE(1)) dut16s (
      .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .valid_in(valid_in),
      .signed_mode(signed_mode), .bias(bias[15:0]), .clear_in(clear_in), .shift_in(shift_in),
      .c_in(c_in[15:0]), .ovf_in(ovf_in), .a_out(a_out16s), .b_out(b_out16s),
      .valid_out(valid_out16s), .signed_out(signed_out16s), .clear_out(clear_out16s),
      .shift_out(shift_out16s), .c_out(c_out16s), .ovf_out(ovf_out16s));

   mmu_cell_simd #(.VAR_SIZE(8), .ACC_SIZE(16), .LANES(4), .SATURATE(0)) dut16w (
      .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .valid_in(valid_in),
      .signed_mode(signed_mode), .bias(bias[15:0]), .clear_in(clear_in), .shift_in(shift_in),
      .c_in(c_in[15:0]), .ovf_in(ovf_in), .a_out(a_out16w), .b_out(b_out16w),
      .valid_out(valid_out16w), .signed_out(signed_out16w), .clear_out(clear_out16w),
      .shift_out(shift_out16w), .c_out(c_out16w), .ovf_out(ovf_out16w));

   // Reinterpret the low n bits of v as an n-bit two's-complement number.
   function automatic longint sext(input longint v, input int n);
      longint m;
      m = longint'(1) <<< n;
      v = v & (m - 1);
      if (v >= (m >>> 1)) v = v - m;
      return v;
   endfunction

   function automatic longint dot_of(input logic [31:0] a, input logic [31:0] b, input logic sm);
      longint s, x, y;
      s = 0;
      for (int i = 0; i < 4; i++) begin
         x = longint'(a[8*i +: 8]);
         y = longint'(b[8*i +: 8]);
         if (sm) begin
            x = sext(x, 8);
            y = sext(y, 8);
         end
         s = s + x * y;
      end
      return s;
   endfunction

   task automatic modelReset();
      for (int k = 0; k < 3; k++) begin
         m_acc[k] = 0; m_c[k] = 0; m_ovf[k] = 0; m_covf[k] = 0;
      end
      m_a = '0; m_b = '0; m_valid = 0; m_sgn = 0; m_clear = 0; m_shift = 0;
   endtask

   // One clock edge of the cell, described from the behavioural rules.
   task automatic modelEdge();
      bit     clr_r, sh_r, restart, o;
      longint d, base, sum, lim, r;
      int     n;
      clr_r   = clear_in && !m_clear;
      sh_r    = shift_in && !m_shift;
      restart = clr_r || sh_r;
      d       = dot_of(a_in, b_in, signed_mode);
      for (int k = 0; k < 3; k++) begin
         n = cfg_bits[k];
         if (sh_r) begin
            m_c[k] = m_acc[k]; m_covf[k] = m_ovf[k];
         end else if (shift_in) begin
            m_c[k] = sext(longint'(c_in), n); m_covf[k] = ovf_in;
         end
         if (restart || valid_in) begin
            base = restart ? sext(longint'(bias), n) : m_acc[k];
            sum  = base + (valid_in ? d : 0);
            lim  = longint'(1) <<< (n - 1);
            o    = (sum > lim - 1) || (sum < -lim);
            if (o && cfg_sat[k]) r = (sum < 0) ? -lim : lim - 1;
            else                 r = sext(sum, n);
            m_acc[k] = r;
            m_ovf[k] = restart ? o : (m_ovf[k] | o);
         end
      end
      m_a = a_in; m_b = b_in; m_valid = valid_in; m_sgn = signed_mode;
      m_clear = clear_in; m_shift = shift_in;
   endtask

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      check("a_out",      a_out32,      m_a);
      check("b_out",      b_out32,      m_b);
      check("valid_out",  valid_out32,  m_valid);
      check("signed_out", signed_out32, m_sgn);
      check("clear_out",  clear_out32,  m_clear);
      check("shift_out",  shift_out32,  m_shift);
      check("c_out32",    $signed(c_out32),  m_c[0]);
      check("ovf_out32",  ovf_out32,         m_covf[0]);
      check("c_out16s",   $signed(c_out16s), m_c[1]);
      check("ovf_out16s", ovf_out16s,        m_covf[1]);
      check("c_out16w",   $signed(c_out16w), m_c[2]);
      check("ovf_out16w", ovf_out16w,        m_covf[2]);
   endtask

   // Inputs change on the falling edge; outputs are checked on the next falling edge.
   task automatic applyStimulus(input bit clr, input bit sh, input bit vld);
      clear_in = clr;
      shift_in = sh;
      valid_in = vld;
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      checkOutput();
   endtask

   task automatic asyncReset();
      #2 rst_n = 1'b0;
      #1 modelReset();
      checkOutput();
      check("rst_c_out", c_out32, 0);
      check("rst_a_out", a_out32, 0);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #2 rst_n = 1'b0;
      modelReset();
      @(negedge clk);
      checkOutput();
      rst_n = 1'b1;

      $display("[TB] signed dot product");
      bias = 10; signed_mode = 1'b1;
      applyStimulus(1, 0, 0);
      a_in = 32'h04030201; b_in = 32'h01010101;
      repeat (3) applyStimulus(0, 0, 1);
      applyStimulus(0, 1, 0);
      check("signed_dot", $signed(c_out32), 40);
      check("signed_ovf", ovf_out32, 0);
      applyStimulus(0, 0, 0);

      $display("[TB] mode select");
      bias = 0; a_in = 32'hFFFFFFFF; b_in = 32'hFFFFFFFF; signed_mode = 1'b0;
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 1);
      applyStimulus(0, 1, 0);
      check("unsigned_ff", $signed(c_out32), 260100);
      applyStimulus(0, 0, 0);
      signed_mode = 1'b1;
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 1);
      applyStimulus(0, 1, 0);
      check("signed_ff", $signed(c_out32), 4);
      applyStimulus(0, 0, 0);

      $display("[TB] overflow");
      bias = 32000; a_in = 32'h7F7F7F7F; b_in = 32'h7F7F7F7F;
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 1);
      applyStimulus(0, 1, 0);
      check("sat_c",   $signed(c_out16s), 32767);
      check("sat_ovf", ovf_out16s, 1);
      check("wrap_c",  $signed(c_out16w), 30980);
      check("wrap_ovf", ovf_out16w, 1);
      check("wide_c",  $signed(c_out32), 96516);
      check("wide_ovf", ovf_out32, 0);
      applyStimulus(0, 0, 0);

      $display("[TB] simultaneous clear and shift");
      bias = 0; a_in = 32'd3; b_in = 32'd1;
      applyStimulus(1, 0, 1);
      applyStimulus(0, 0, 0);
      a_in = 32'd7; bias = 5;
      applyStimulus(1, 1, 1);
      check("simul_old", $signed(c_out32), 3);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 1, 0);
      check("simul_new", $signed(c_out32), 12);
      applyStimulus(0, 0, 0);

      $display("[TB] double-buffered drain");
      bias = 100; tile_sum = 100;
      applyStimulus(1, 0, 0);
      repeat (4) begin
         a_in = $urandom; b_in = $urandom;
         tile_sum = tile_sum + dot_of(a_in, b_in, signed_mode);
         applyStimulus(0, 0, 1);
      end
      c_in = 32'h1234; ovf_in = 1'b0;
      a_in = $urandom; b_in = $urandom;
      next_tile = 100 + dot_of(a_in, b_in, signed_mode);
      applyStimulus(0, 1, 1);
      check("drain_first", $signed(c_out32), tile_sum);
      for (int i = 0; i < 2; i++) begin
         a_in = $urandom; b_in = $urandom;
         next_tile = next_tile + dot_of(a_in, b_in, signed_mode);
         applyStimulus(0, 1, 1);
         check("drain_chain", $signed(c_out32), 32'h1234);
      end
      repeat (3) begin
         a_in = $urandom; b_in = $urandom;
         next_tile = next_tile + dot_of(a_in, b_in, signed_mode);
         applyStimulus(0, 0, 1);
      end
      applyStimulus(0, 1, 0);
      check("drain_next_tile", $signed(c_out32), next_tile);
      applyStimulus(0, 0, 0);

      $display("[TB] held clear");
      bias = -32'sd50; tile_sum = -50;
      applyStimulus(1, 0, 0);
      repeat (3) begin
         a_in = $urandom; b_in = $urandom;
         tile_sum = tile_sum + dot_of(a_in, b_in, signed_mode);
         applyStimulus(1, 0, 1);
      end
      applyStimulus(0, 1, 0);
      check("held_clear", $signed(c_out32), tile_sum);
      applyStimulus(0, 0, 0);

      $display("[TB] reset mid-tile");
      bias = 77;
      applyStimulus(1, 0, 0);
      repeat (2) begin
         a_in = $urandom; b_in = $urandom;
         applyStimulus(0, 0, 1);
      end
      asyncReset();
      tile_sum = 0;
      repeat (2) begin
         a_in = $urandom; b_in = $urandom;
         tile_sum = tile_sum + dot_of(a_in, b_in, signed_mode);
         applyStimulus(0, 0, 1);
      end
      applyStimulus(0, 1, 0);
      check("reset_resume", $signed(c_out32), tile_sum);
      applyStimulus(0, 0, 0);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         a_in = $urandom; b_in = $urandom;
         signed_mode = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0: bias = $urandom;
            1: bias = 32'h7FFF0000 + $urandom_range(0, 65535);
            2: bias = 32'h00007000 + $urandom_range(0, 4095);
            default: bias = 32'hFFFF8000 + $urandom_range(0, 4095);
         endcase
         c_in = $urandom; ovf_in = 1'($urandom_range(0, 1));
         applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 3) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
